// File: rtl/scale_tracker.sv
// scale_tracker
//   Maps raster (hcount, vcount) to source-frame coordinates for an integer
//   scale factor per axis (1..MAX_SCALE). Sub-pixel counters replace
//   dividers. Scale changes are taken only at frame start (hcount==vcount==0).
//   Also produces the linear frame-buffer read address and a sticky
//   raster-discontinuity flag. Outputs are registered and describe the inputs
//   sampled two clock edges earlier.
//
// Ports
//   clk_in             pixel clock
//   rst_n_in           asynchronous active-low reset
//   hcount_in          raster column (+1 per cycle, 0 at row start, may stall)
//   vcount_in          raster row
//   scale_x_in         requested horizontal factor (sampled at frame start)
//   scale_y_in         requested vertical factor (sampled at frame start)
//   scaled_hcount_out  source column
//   scaled_vcount_out  source row
//   valid_addr_out     source coordinate lies inside SRC_W x SRC_H
//   addr_out           scaled_vcount*SRC_W + scaled_hcount, 0 when invalid
//   sync_err_out       sticky discontinuity flag, cleared at frame start
module scale_tracker #(
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int SRC_W     = 240,
  parameter int SRC_H     = 320,
  parameter int MAX_SCALE = 4,
  parameter int S_WIDTH   = 3,
  parameter int ADDR_W    = 17
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic [S_WIDTH-1:0] scale_x_in,
  input  logic [S_WIDTH-1:0] scale_y_in,
  output logic [H_WIDTH-1:0] scaled_hcount_out,
  output logic [V_WIDTH-1:0] scaled_vcount_out,
  output logic               valid_addr_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               sync_err_out
);

  localparam logic [31:0] LP_SRC_W = SRC_W;
  localparam logic [31:0] LP_SRC_H = SRC_H;

  // Illegal requests (0 or above MAX_SCALE) fall back to 1:1.
  function automatic logic [S_WIDTH-1:0] legal_scale(input logic [S_WIDTH-1:0] s);
    if ((s == '0) || (s > S_WIDTH'(MAX_SCALE))) return S_WIDTH'(1);
    return s;
  endfunction

  // Stage 1 state
  logic [S_WIDTH-1:0] r_scale_x, r_scale_y;
  logic [S_WIDTH-1:0] r_hsub, r_vsub;
  logic [H_WIDTH-1:0] r_hscaled, r_hprev;
  logic [V_WIDTH-1:0] r_vscaled, r_vprev;
  logic               r_err;

  // Stage 2 state
  logic [H_WIDTH-1:0] r_hout;
  logic [V_WIDTH-1:0] r_vout;
  logic               r_valid;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_err_out;

  logic               w_fs;
  logic [S_WIDTH-1:0] w_scale_x, w_scale_y;
  logic [S_WIDTH-1:0] w_hsub_nxt, w_vsub_nxt;
  logic [H_WIDTH-1:0] w_hscaled_nxt;
  logic [V_WIDTH-1:0] w_vscaled_nxt;
  logic               w_hdisc, w_vdisc, w_err_nxt;
  logic               w_valid;
  logic [ADDR_W-1:0]  w_addr;

  assign w_fs = (hcount_in == '0) && (vcount_in == '0);

  // The newly requested scale already governs the frame-start pixel.
  assign w_scale_x = w_fs ? legal_scale(scale_x_in) : r_scale_x;
  assign w_scale_y = w_fs ? legal_scale(scale_y_in) : r_scale_y;

  // Horizontal tracker
  always_comb begin
    w_hsub_nxt    = r_hsub;
    w_hscaled_nxt = r_hscaled;
    w_hdisc       = 1'b0;
    if (hcount_in == '0) begin
      w_hsub_nxt    = '0;
      w_hscaled_nxt = '0;
    end else if (hcount_in == r_hprev + H_WIDTH'(1)) begin
      if (r_hsub >= w_scale_x - S_WIDTH'(1)) begin
        w_hsub_nxt = '0;
        if (r_hscaled != '1) w_hscaled_nxt = r_hscaled + H_WIDTH'(1);
      end else begin
        w_hsub_nxt = r_hsub + S_WIDTH'(1);
      end
    end else if (hcount_in != r_hprev) begin
      w_hdisc = 1'b1;
    end
  end

  // Vertical tracker
  always_comb begin
    w_vsub_nxt    = r_vsub;
    w_vscaled_nxt = r_vscaled;
    w_vdisc       = 1'b0;
    if (vcount_in == '0) begin
      w_vsub_nxt    = '0;
      w_vscaled_nxt = '0;
    end else if (vcount_in == r_vprev + V_WIDTH'(1)) begin
      if (r_vsub >= w_scale_y - S_WIDTH'(1)) begin
        w_vsub_nxt = '0;
        if (r_vscaled != '1) w_vscaled_nxt = r_vscaled + V_WIDTH'(1);
      end else begin
        w_vsub_nxt = r_vsub + S_WIDTH'(1);
      end
    end else if (vcount_in != r_vprev) begin
      w_vdisc = 1'b1;
    end
  end

  // Frame start restarts the sticky flag, but a discontinuity seen on that
  // same cycle still wins.
  assign w_err_nxt = w_fs ? (w_hdisc | w_vdisc) : (r_err | w_hdisc | w_vdisc);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_scale_x <= S_WIDTH'(1);
      r_scale_y <= S_WIDTH'(1);
      r_hsub    <= '0;
      r_vsub    <= '0;
      r_hscaled <= '0;
      r_vscaled <= '0;
      r_hprev   <= '0;
      r_vprev   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_scale_x <= w_scale_x;
      r_scale_y <= w_scale_y;
      r_hsub    <= w_hsub_nxt;
      r_vsub    <= w_vsub_nxt;
      r_hscaled <= w_hscaled_nxt;
      r_vscaled <= w_vscaled_nxt;
      r_hprev   <= hcount_in;
      r_vprev   <= vcount_in;
      r_err     <= w_err_nxt;
    end
  end

  assign w_valid = (32'(r_hscaled) < LP_SRC_W) && (32'(r_vscaled) < LP_SRC_H);
  assign w_addr  = w_valid ? (ADDR_W'(r_vscaled) * ADDR_W'(SRC_W) + ADDR_W'(r_hscaled)) : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hout    <= '0;
      r_vout    <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_err_out <= 1'b0;
    end else begin
      r_hout    <= r_hscaled;
      r_vout    <= r_vscaled;
      r_valid   <= w_valid;
      r_addr    <= w_addr;
      r_err_out <= r_err;
    end
  end

  assign scaled_hcount_out = r_hout;
  assign scaled_vcount_out = r_vout;
  assign valid_addr_out    = r_valid;
  assign addr_out          = r_addr;
  assign sync_err_out      = r_err_out;

endmodule

// File: tb/tb_scale_tracker.sv
// Testbench for scale_tracker: scoreboard of expected outputs, pushed when a
// raster sample is driven and compared two clock edges later.
module tb_scale_tracker;

  localparam int HW    = 11;
  localparam int VW    = 10;
  localparam int SW    = 3;
  localparam int AW    = 17;
  localparam int SRC_W = 240;
  localparam int SRC_H = 320;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [HW-1:0] hcount_in;
  logic [VW-1:0] vcount_in;
  logic [SW-1:0] scale_x_in, scale_y_in;
  logic [HW-1:0] scaled_hcount_out;
  logic [VW-1:0] scaled_vcount_out;
  logic          valid_addr_out;
  logic [AW-1:0] addr_out;
  logic          sync_err_out;

  always #5 clk_in = ~clk_in;

  scale_tracker #(
    .H_WIDTH(HW), .V_WIDTH(VW), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .MAX_SCALE(4), .S_WIDTH(SW), .ADDR_W(AW)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .scale_x_in(scale_x_in), .scale_y_in(scale_y_in),
    .scaled_hcount_out(scaled_hcount_out), .scaled_vcount_out(scaled_vcount_out),
    .valid_addr_out(valid_addr_out), .addr_out(addr_out),
    .sync_err_out(sync_err_out)
  );

  typedef struct {
    logic [HW-1:0] eh;
    logic [VW-1:0] ev;
    logic          evalid;
    logic [AW-1:0] eaddr;
    logic          eerr;
    int            tag;
    int            h;
    int            v;
  } exp_t;

  typedef struct {
    int h, v, sx, sy, eh, ev, evalid, eaddr, eerr;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[14];
  int   n_pass  = 0;
  int   n_total = 0;
  int   act_sx  = 1;
  int   act_sy  = 1;

  task automatic compare_out(input exp_t e);
    n_total++;
    if (scaled_hcount_out === e.eh && scaled_vcount_out === e.ev &&
        valid_addr_out === e.evalid && addr_out === e.eaddr && sync_err_out === e.eerr) begin
      n_pass++;
    end else begin
      $display("FAIL map tag=%0d in=(%0d,%0d) got h=%0d v=%0d valid=%0b addr=%0d err=%0b want h=%0d v=%0d valid=%0b addr=%0d err=%0b",
               e.tag, e.h, e.v, scaled_hcount_out, scaled_vcount_out, valid_addr_out,
               addr_out, sync_err_out, e.eh, e.ev, e.evalid, e.eaddr, e.eerr);
    end
  endtask

  task automatic step_exp(input int h, input int v, input int sx, input int sy,
                          input int eh, input int ev, input int evalid,
                          input int eaddr, input int eerr, input int tag);
    exp_t e;
    hcount_in  = HW'(h);
    vcount_in  = VW'(v);
    scale_x_in = SW'(sx);
    scale_y_in = SW'(sy);
    e.eh     = HW'(eh);
    e.ev     = VW'(ev);
    e.evalid = (evalid != 0);
    e.eaddr  = AW'(eaddr);
    e.eerr   = (eerr != 0);
    e.tag    = tag;
    e.h      = h;
    e.v      = v;
    sbq.push_back(e);
    @(posedge clk_in);
    #1;
    if (sbq.size() >= 2) compare_out(sbq.pop_front());
  endtask

  task automatic step_calc(input int h, input int v, input int sx, input int sy,
                           input int eh, input int ev, input int eerr, input int tag);
    int ok;
    ok = (eh < SRC_W && ev < SRC_H) ? 1 : 0;
    step_exp(h, v, sx, sy, eh, ev, ok, (ok != 0) ? ev * SRC_W + eh : 0, eerr, tag);
  endtask

  // Continuous raster model: source coordinate is the raster coordinate
  // divided by the scale captured at the last frame start.
  task automatic step_model(input int h, input int v, input int sx, input int sy, input int tag);
    if (h == 0 && v == 0) begin
      act_sx = (sx == 0 || sx > 4) ? 1 : sx;
      act_sy = (sy == 0 || sy > 4) ? 1 : sy;
    end
    step_calc(h, v, sx, sy, h / act_sx, v / act_sy, 0, tag);
  endtask

  task automatic row(input int v, input int hmax, input int sx, input int sy, input int tag);
    for (int h = 0; h <= hmax; h++) step_model(h, v, sx, sy, tag);
  endtask

  initial begin
    exp_t z;
    z.eh = '0; z.ev = '0; z.evalid = 1'b0; z.eaddr = '0; z.eerr = 1'b0;
    z.h = 0; z.v = 0;

    // scale 3/1, two short rows; expectations worked out by hand
    tbl[0]  = '{0, 0, 3, 1, 0, 0, 1,   0, 0};
    tbl[1]  = '{1, 0, 3, 1, 0, 0, 1,   0, 0};
    tbl[2]  = '{2, 0, 3, 1, 0, 0, 1,   0, 0};
    tbl[3]  = '{3, 0, 3, 1, 1, 0, 1,   1, 0};
    tbl[4]  = '{4, 0, 3, 1, 1, 0, 1,   1, 0};
    tbl[5]  = '{5, 0, 3, 1, 1, 0, 1,   1, 0};
    tbl[6]  = '{6, 0, 3, 1, 2, 0, 1,   2, 0};
    tbl[7]  = '{0, 1, 3, 1, 0, 1, 1, 240, 0};
    tbl[8]  = '{1, 1, 3, 1, 0, 1, 1, 240, 0};
    tbl[9]  = '{2, 1, 3, 1, 0, 1, 1, 240, 0};
    tbl[10] = '{3, 1, 3, 1, 1, 1, 1, 241, 0};
    tbl[11] = '{4, 1, 3, 1, 1, 1, 1, 241, 0};
    tbl[12] = '{5, 1, 3, 1, 1, 1, 1, 241, 0};
    tbl[13] = '{6, 1, 3, 1, 2, 1, 1, 242, 0};

    rst_n_in = 1'b0;
    hcount_in = '0; vcount_in = '0; scale_x_in = '0; scale_y_in = '0;
    #23;
    z.tag = 0;
    compare_out(z);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // 1: scale 4/2, rows shortened except where the boundaries are crossed
    row(0, 1023, 4, 2, 1);
    for (int v = 1; v <= 638; v++) row(v, 2, 4, 2, 1);
    row(639, 965, 4, 2, 1);
    row(640, 3, 4, 2, 1);
    for (int v = 641; v <= 767; v++) row(v, 1, 4, 2, 1);

    // 2: table of hand-derived vectors
    for (int i = 0; i < 14; i++)
      step_exp(tbl[i].h, tbl[i].v, tbl[i].sx, tbl[i].sy, tbl[i].eh, tbl[i].ev,
               tbl[i].evalid, tbl[i].eaddr, tbl[i].eerr, 2);

    // 3: scale_x request changes mid-frame; takes effect only at next frame
    for (int v = 0; v <= 49; v++) row(v, 1, 1, 1, 3);
    for (int h = 0; h <= 300; h++) step_model(h, 50, (h >= 100) ? 4 : 1, 1, 3);
    row(51, 5, 4, 1, 3);
    row(0, 8, 4, 1, 3);
    row(1, 3, 4, 1, 3);

    // 4: illegal scale requests fall back to identity
    for (int v = 0; v <= 3; v++) row(v, 10, 0, 7, 4);

    // 5: horizontal jump and stall, then vertical jump
    for (int h = 0; h <= 10; h++) step_calc(h, 0, 1, 1, h, 0, 0, 5);
    step_calc(20, 0, 1, 1, 10, 0, 1, 5);
    for (int i = 0; i < 3; i++) step_calc(20, 0, 1, 1, 10, 0, 1, 5);
    step_calc(21, 0, 1, 1, 11, 0, 1, 5);
    step_calc(0, 0, 1, 1, 0, 0, 0, 5);
    step_calc(1, 0, 1, 1, 1, 0, 0, 5);
    step_calc(0, 1, 1, 1, 0, 1, 0, 5);
    step_calc(0, 4, 1, 1, 0, 1, 1, 5);
    step_calc(1, 4, 1, 1, 1, 1, 1, 5);

    // 6: asynchronous reset mid-frame, then a fresh raster
    for (int v = 0; v <= 299; v++) row(v, 0, 1, 1, 6);
    row(300, 500, 1, 1, 6);
    rst_n_in = 1'b0;
    #1;
    z.tag = 6; z.h = 500; z.v = 300;
    compare_out(z);
    sbq.delete();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int v = 0; v <= 3; v++) row(v, 9, 2, 2, 7);

    @(posedge clk_in);
    #1;
    if (sbq.size() > 0) compare_out(sbq.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
